// File: rtl/comm_pkg.sv
// Shared types for the single-input, dual-output wormhole flit switch.
package comm_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned DEST_BIT   = DW_DEFAULT - 3;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } route_state_t;

  function automatic flit_type_t flit_type(input logic [1:0] tbits);
    return flit_type_t'(tbits);
  endfunction

endpackage

// File: rtl/comm_fifo.sv
// Synchronous show-ahead FIFO; push on full is accepted only alongside a pop.
module comm_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/comm_system.sv
// Flit switch: input FIFO, wormhole route stage with destination lock, two output FIFOs.
module comm_system
  import comm_pkg::*;
#(
  parameter int unsigned DW        = DW_DEFAULT,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] data_i_stab,
  input  logic          valid_i_stab,
  output logic          ready_o_stab,
  output logic [DW-1:0] data_o_flee0,
  output logic          valid_o_flee0,
  input  logic          ready_i_flee0,
  output logic [DW-1:0] data_o_flee1,
  output logic          valid_o_flee1,
  input  logic          ready_i_flee1
);

  localparam int unsigned DST = DW - 3;

  logic [DW-1:0] in_dout;
  logic          in_full, in_empty, in_push, in_pop;
  logic          f0_full, f0_empty, f0_push, f0_pop;
  logic          f1_full, f1_empty, f1_push, f1_pop;
  logic          room0, room1, fwd, tgt;
  flit_type_t    ftype;
  route_state_t  state_q, state_d;
  logic          dest_q, dest_d;

  assign ready_o_stab  = rstn & ~in_full;
  assign in_push       = valid_i_stab & ready_o_stab;
  assign valid_o_flee0 = rstn & ~f0_empty;
  assign valid_o_flee1 = rstn & ~f1_empty;
  assign f0_pop        = valid_o_flee0 & ready_i_flee0;
  assign f1_pop        = valid_o_flee1 & ready_i_flee1;
  assign room0         = ~f0_full | f0_pop;
  assign room1         = ~f1_full | f1_pop;
  assign ftype         = flit_type(in_dout[DW-1:DW-2]);

  comm_fifo #(.DW(DW), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .rstn(rstn), .push_i(in_push), .pop_i(in_pop),
    .din_i(data_i_stab), .dout_o(in_dout), .full_o(in_full), .empty_o(in_empty)
  );

  comm_fifo #(.DW(DW), .DEPTH(OUT_DEPTH)) u_flee0_fifo (
    .clk(clk), .rstn(rstn), .push_i(f0_push), .pop_i(f0_pop),
    .din_i(in_dout), .dout_o(data_o_flee0), .full_o(f0_full), .empty_o(f0_empty)
  );

  comm_fifo #(.DW(DW), .DEPTH(OUT_DEPTH)) u_flee1_fifo (
    .clk(clk), .rstn(rstn), .push_i(f1_push), .pop_i(f1_pop),
    .din_i(in_dout), .dout_o(data_o_flee1), .full_o(f1_full), .empty_o(f1_empty)
  );

  // Orphan BODY/TAIL flits (no lock) are popped without being forwarded.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    in_pop  = 1'b0;
    f0_push = 1'b0;
    f1_push = 1'b0;
    fwd     = 1'b0;
    tgt     = 1'b0;
    if (!in_empty) begin
      case (ftype)
        HEAD, SINGLE: begin
          fwd = 1'b1;
          tgt = in_dout[DST];
        end
        default: begin
          if (state_q == LOCKED) begin
            fwd = 1'b1;
            tgt = dest_q;
          end else begin
            in_pop = 1'b1;
          end
        end
      endcase
      if (fwd && (tgt ? room1 : room0)) begin
        in_pop  = 1'b1;
        f0_push = ~tgt;
        f1_push = tgt;
        case (ftype)
          HEAD: begin
            state_d = LOCKED;
            dest_d  = tgt;
          end
          TAIL:    state_d = IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      dest_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

endmodule

// File: tb/tb_comm_system.sv
// Directed and soak bench for comm_system: reset, latency, ordering, backpressure, orphans.
module tb_comm_system;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] data_i_stab = '0;
  logic        valid_i_stab = 1'b0;
  logic        ready_o_stab;
  logic [31:0] data_o_flee0, data_o_flee1;
  logic        valid_o_flee0, valid_o_flee1;
  logic        ready_i_flee0 = 1'b1;
  logic        ready_i_flee1 = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  bit          soak_on  = 1'b0;

  logic [31:0] out0_log[$], out1_log[$];
  int unsigned out0_cyc[$];
  logic [31:0] exp0[$], exp1[$];

  always #5 clk = ~clk;

  comm_system #(.DW(32), .IN_DEPTH(4), .OUT_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .data_i_stab(data_i_stab), .valid_i_stab(valid_i_stab), .ready_o_stab(ready_o_stab),
    .data_o_flee0(data_o_flee0), .valid_o_flee0(valid_o_flee0), .ready_i_flee0(ready_i_flee0),
    .data_o_flee1(data_o_flee1), .valid_o_flee1(valid_o_flee1), .ready_i_flee1(ready_i_flee1)
  );

  always @(posedge clk) cyc++;

  // Values at the negedge are those the next posedge transfers.
  always @(negedge clk) begin
    if (rstn && valid_o_flee0 && ready_i_flee0) begin
      out0_log.push_back(data_o_flee0);
      out0_cyc.push_back(cyc);
    end
    if (rstn && valid_o_flee1 && ready_i_flee1) out1_log.push_back(data_o_flee1);
  end

  always @(posedge clk) begin
    if (soak_on) begin
      #1;
      ready_i_flee0 = ((cyc % 16) < 6);
      ready_i_flee1 = ((cyc % 20) < 8);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the flit is accepted.
  task automatic send(input logic [31:0] f);
    int unsigned w = 0;
    data_i_stab  = f;
    valid_i_stab = 1'b1;
    @(negedge clk);
    while (!ready_o_stab && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!ready_o_stab) check("send_timeout", 32'(ready_o_stab), 32'd1);
    @(posedge clk); #1;
    valid_i_stab = 1'b0;
  endtask

  task automatic wait_logs(input int unsigned n0, input int unsigned n1, input int unsigned bound);
    int unsigned w = 0;
    while ((out0_log.size() < n0 || out1_log.size() < n1) && w < bound) begin
      @(negedge clk);
      w++;
    end
    if (w >= bound) check("drain_timeout", 32'(out0_log.size() + out1_log.size()), 32'(n0 + n1));
  endtask

  task automatic clear_logs();
    out0_log.delete();
    out1_log.delete();
    out0_cyc.delete();
  endtask

  initial begin
    logic [31:0] pkt [20];
    logic [31:0] f;
    int unsigned idx, sent, len, w;
    logic [1:0]  ty;
    logic        dst;

    // Reset held 7 cycles
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready_o_stab), 32'd0);
    check("rst_v0", 32'(valid_o_flee0), 32'd0);
    check("rst_v1", 32'(valid_o_flee1), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready_o_stab), 32'd1);

    // Orphan body is consumed and never output
    @(posedge clk); #1;
    clear_logs();
    data_i_stab  = 32'h0000_0007;
    valid_i_stab = 1'b1;
    @(negedge clk);
    check("orphan_ready", 32'(ready_o_stab), 32'd1);
    @(posedge clk); #1;
    valid_i_stab = 1'b0;
    repeat (6) @(negedge clk);
    check("orphan_out", 32'(out0_log.size() + out1_log.size()), 32'd0);
    check("orphan_v0", 32'(valid_o_flee0), 32'd0);

    // Single to port 1: visible after two edges
    @(posedge clk); #1;
    clear_logs();
    data_i_stab  = 32'hE000_0005;
    valid_i_stab = 1'b1;
    @(negedge clk);
    check("single_ready", 32'(ready_o_stab), 32'd1);
    @(posedge clk); #1;
    valid_i_stab = 1'b0;
    @(negedge clk);
    check("single_v1_early", 32'(valid_o_flee1), 32'd0);
    @(negedge clk);
    check("single_v1", 32'(valid_o_flee1), 32'd1);
    check("single_d1", data_o_flee1, 32'hE000_0005);
    check("single_v0", 32'(valid_o_flee0), 32'd0);
    repeat (4) @(negedge clk);
    check("single_n1", 32'(out1_log.size()), 32'd1);
    check("single_n0", 32'(out0_log.size()), 32'd0);

    // 3-flit packet to port 0, back to back
    @(posedge clk); #1;
    clear_logs();
    send(32'h4000_0001);
    send(32'h0000_0002);
    send(32'h8000_0003);
    wait_logs(3, 0, 50);
    check("pkt_n0", 32'(out0_log.size()), 32'd3);
    if (out0_log.size() == 3) begin
      check("pkt_f0", out0_log[0], 32'h4000_0001);
      check("pkt_f1", out0_log[1], 32'h0000_0002);
      check("pkt_f2", out0_log[2], 32'h8000_0003);
      check("pkt_gap1", out0_cyc[1] - out0_cyc[0], 32'd1);
      check("pkt_gap2", out0_cyc[2] - out0_cyc[1], 32'd1);
    end
    check("pkt_n1", 32'(out1_log.size()), 32'd0);

    // Backpressure on port 0: 12 accepted, then all 20 delivered in order
    @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < 20; i++)
      pkt[i] = (i == 0) ? 32'h4000_0100 : (i == 19) ? 32'h8000_0100 + 32'(i) : 32'h0000_0100 + 32'(i);
    ready_i_flee0 = 1'b0;
    idx = 0;
    data_i_stab  = pkt[0];
    valid_i_stab = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o_stab && valid_i_stab) idx++;
      @(posedge clk); #1;
      if (idx < 20) data_i_stab = pkt[idx];
      else valid_i_stab = 1'b0;
    end
    check("bp_accepted", 32'(idx), 32'd12);
    @(negedge clk);
    check("bp_ready_low", 32'(ready_o_stab), 32'd0);
    check("bp_v0", 32'(valid_o_flee0), 32'd1);
    check("bp_head", data_o_flee0, 32'h4000_0100);
    @(posedge clk); #1;
    ready_i_flee0 = 1'b1;
    w = 0;
    while (idx < 20 && w < 200) begin
      @(negedge clk);
      if (ready_o_stab && valid_i_stab) idx++;
      @(posedge clk); #1;
      if (idx < 20) data_i_stab = pkt[idx];
      else valid_i_stab = 1'b0;
      w++;
    end
    valid_i_stab = 1'b0;
    check("bp_all_sent", 32'(idx), 32'd20);
    wait_logs(20, 0, 100);
    check("bp_n0", 32'(out0_log.size()), 32'd20);
    for (int i = 0; i < 20 && i < out0_log.size(); i++) check("bp_flit", out0_log[i], pkt[i]);
    check("bp_n1", 32'(out1_log.size()), 32'd0);

    // Random soak under periodic port readiness
    @(posedge clk); #1;
    clear_logs();
    soak_on = 1'b1;
    sent = 0;
    while (sent < 10000) begin
      len = $urandom_range(1, 6);
      dst = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        if (len == 1)          ty = 2'b11;
        else if (k == 0)       ty = 2'b01;
        else if (k == len - 1) ty = 2'b10;
        else                   ty = 2'b00;
        // Non-head flits carry a random dest bit that routing must ignore
        f = {ty, (k == 0) ? dst : 1'($urandom_range(0, 1)), 29'(sent)};
        if (dst) exp1.push_back(f);
        else exp0.push_back(f);
        send(f);
        sent++;
      end
    end
    wait_logs(exp0.size(), exp1.size(), 5000);
    soak_on = 1'b0;
    check("soak_n0", 32'(out0_log.size()), 32'(exp0.size()));
    check("soak_n1", 32'(out1_log.size()), 32'(exp1.size()));
    for (int i = 0; i < exp0.size() && i < out0_log.size(); i++) check("soak_p0", out0_log[i], exp0[i]);
    for (int i = 0; i < exp1.size() && i < out1_log.size(); i++) check("soak_p1", out1_log[i], exp1[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
